// File: rtl/top.sv
// Stored-program 8-bit CPU with a unified 256-word program/data memory.
// The control FSM sequences fetch, decode and the two-byte memory/branch instructions.

module ram #(
    parameter int WORD_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [WORD_SIZE-1:0] addr,
    input  logic [WORD_SIZE-1:0] wdata,
    output logic [WORD_SIZE-1:0] rdata
);

    logic [WORD_SIZE-1:0] memory [0:255];

    // Contents are deliberately not reset so a program survives a CPU reset.
    assign rdata = memory[addr];

    always_ff @(posedge clk) begin
        if (we) begin
            memory[addr] <= wdata;
        end
    end

endmodule

module top #(
    parameter int WORD_SIZE = 8
) (
    input logic clk,
    input logic rst
);

    typedef enum logic [3:0] {
        FET1, FET2, DEC, RD1, RD2, WR1, WR2, BR1, BR2, HALT
    } state_t;

    localparam logic [3:0] OP_NOP = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_AND = 4'b0011;
    localparam logic [3:0] OP_NOT = 4'b0100;
    localparam logic [3:0] OP_RD  = 4'b0101;
    localparam logic [3:0] OP_WR  = 4'b0110;
    localparam logic [3:0] OP_BR  = 4'b0111;
    localparam logic [3:0] OP_BRZ = 4'b1000;

    state_t               state, next_state;
    logic [WORD_SIZE-1:0] pc, next_pc;
    logic [WORD_SIZE-1:0] ir, next_ir;
    logic [WORD_SIZE-1:0] mar, next_mar;
    logic [WORD_SIZE-1:0] regs [0:3];
    logic [WORD_SIZE-1:0] next_regs [0:3];
    logic                 z, next_z;

    logic [WORD_SIZE-1:0] mem_data;
    logic                 mem_we;
    logic [3:0]           opcode;
    logic [1:0]           src;
    logic [1:0]           dest;
    logic [WORD_SIZE-1:0] alu_result;

    assign opcode = ir[7:4];
    assign src    = ir[3:2];
    assign dest   = ir[1:0];
    assign mem_we = (state == WR2);

    ram #(.WORD_SIZE(WORD_SIZE)) Memory (
        .clk   (clk),
        .we    (mem_we),
        .addr  (mar),
        .wdata (regs[src]),
        .rdata (mem_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= FET1;
            pc    <= '0;
            ir    <= '0;
            mar   <= '0;
            z     <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                regs[i] <= '0;
            end
        end else begin
            state <= next_state;
            pc    <= next_pc;
            ir    <= next_ir;
            mar   <= next_mar;
            z     <= next_z;
            for (int i = 0; i < 4; i++) begin
                regs[i] <= next_regs[i];
            end
        end
    end

    // Operands come from the registered file, so src == dest sees the old value twice.
    always_comb begin
        alu_result = '0;
        case (opcode)
            OP_ADD:  alu_result = regs[dest] + regs[src];
            OP_SUB:  alu_result = regs[dest] - regs[src];
            OP_AND:  alu_result = regs[dest] & regs[src];
            OP_NOT:  alu_result = ~regs[src];
            default: alu_result = '0;
        endcase
    end

    always_comb begin
        next_state = state;
        next_pc    = pc;
        next_ir    = ir;
        next_mar   = mar;
        next_z     = z;
        for (int i = 0; i < 4; i++) begin
            next_regs[i] = regs[i];
        end

        case (state)
            FET1: begin
                next_mar   = pc;
                next_state = FET2;
            end
            FET2: begin
                next_ir    = mem_data;
                next_pc    = pc + 1'b1;
                next_state = DEC;
            end
            DEC: begin
                case (opcode)
                    OP_NOP: next_state = FET1;
                    OP_ADD, OP_SUB, OP_AND, OP_NOT: begin
                        next_regs[dest] = alu_result;
                        next_z          = (alu_result == '0);
                        next_state      = FET1;
                    end
                    OP_RD: begin
                        next_mar   = pc;
                        next_state = RD1;
                    end
                    OP_WR: begin
                        next_mar   = pc;
                        next_state = WR1;
                    end
                    OP_BR: begin
                        next_mar   = pc;
                        next_state = BR1;
                    end
                    OP_BRZ: begin
                        if (z) begin
                            next_mar   = pc;
                            next_state = BR1;
                        end else begin
                            next_pc    = pc + 1'b1;
                            next_state = FET1;
                        end
                    end
                    default: next_state = HALT;
                endcase
            end
            RD1: begin
                next_mar   = mem_data;
                next_pc    = pc + 1'b1;
                next_state = RD2;
            end
            RD2: begin
                next_regs[dest] = mem_data;
                next_state      = FET1;
            end
            WR1: begin
                next_mar   = mem_data;
                next_pc    = pc + 1'b1;
                next_state = WR2;
            end
            WR2: next_state = FET1;
            BR1: begin
                next_mar   = mem_data;
                next_state = BR2;
            end
            BR2: begin
                next_pc    = mem_data;
                next_state = FET1;
            end
            HALT:    next_state = HALT;
            default: next_state = FET1;
        endcase
    end

endmodule

// File: tb/tb_top.sv
// Directed testbench for the 8-bit CPU: loads programs straight into memory
// and checks architectural state after hand-counted numbers of clock cycles.

module tb_top;

    logic clk;
    logic rst;
    int   compared;
    int   mismatched;

    top #(.WORD_SIZE(8)) dut (
        .clk (clk),
        .rst (rst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 256; i++) dut.Memory.memory[i] = 8'h00;
        dut.Memory.memory[128] = 8'd10;
        dut.Memory.memory[129] = 8'd20;
        dut.Memory.memory[130] = 8'd30;
        dut.Memory.memory[131] = 8'd40;
        dut.Memory.memory[134] = 8'd139;
        dut.Memory.memory[150] = 8'd0;
        dut.Memory.memory[0]   = 8'h00;
        dut.Memory.memory[1]   = 8'h50; dut.Memory.memory[2]  = 8'd128;
        dut.Memory.memory[3]   = 8'h51; dut.Memory.memory[4]  = 8'd129;
        dut.Memory.memory[5]   = 8'h52; dut.Memory.memory[6]  = 8'd130;
        dut.Memory.memory[7]   = 8'h53; dut.Memory.memory[8]  = 8'd131;
        dut.Memory.memory[9]   = 8'h21;
        dut.Memory.memory[10]  = 8'h80; dut.Memory.memory[11] = 8'd134;
        dut.Memory.memory[12]  = 8'h21;
        dut.Memory.memory[13]  = 8'h80; dut.Memory.memory[14] = 8'd134;
        dut.Memory.memory[139] = 8'h00;
        dut.Memory.memory[140] = 8'h6C; dut.Memory.memory[141] = 8'd200;
        dut.Memory.memory[142] = 8'h70; dut.Memory.memory[143] = 8'd150;
        run(3);
        compared++;
        if (dut.pc !== 8'd0) begin
            mismatched++; $display("[TB] FAIL reset_pc got %0d want 0", dut.pc);
        end
        for (int i = 0; i < 4; i++) begin
            compared++;
            if (dut.regs[i] !== 8'd0) begin
                mismatched++; $display("[TB] FAIL reset_r%0d got %0d want 0", i, dut.regs[i]);
            end
        end
        compared++;
        if (dut.z !== 1'b0) begin
            mismatched++; $display("[TB] FAIL reset_z got %0b want 0", dut.z);
        end
        compared++;
        if (dut.Memory.memory[128] !== 8'd10 || dut.Memory.memory[1] !== 8'h50) begin
            mismatched++;
            $display("[TB] FAIL reset_mem got %0d/%0h want 10/50",
                     dut.Memory.memory[128], dut.Memory.memory[1]);
        end
    endtask

    task automatic test_load();
        release_reset();
        run(23);
        for (int i = 0; i < 4; i++) begin
            compared++;
            if (dut.regs[i] !== 8'(10 * (i + 1))) begin
                mismatched++;
                $display("[TB] FAIL load_r%0d got %0d want %0d", i, dut.regs[i], 10 * (i + 1));
            end
        end
        compared++;
        if (dut.pc !== 8'd9) begin
            mismatched++; $display("[TB] FAIL load_pc got %0d want 9", dut.pc);
        end
    endtask

    task automatic test_not_taken();
        run(3);
        compared++;
        if (dut.regs[1] !== 8'd10 || dut.z !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL sub1 got r1=%0d z=%0b want r1=10 z=0", dut.regs[1], dut.z);
        end
        run(3);
        compared++;
        if (dut.pc !== 8'd12) begin
            mismatched++; $display("[TB] FAIL brz_not_taken_pc got %0d want 12", dut.pc);
        end
    endtask

    task automatic test_taken();
        run(3);
        compared++;
        if (dut.regs[1] !== 8'd0 || dut.z !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL sub2 got r1=%0d z=%0b want r1=0 z=1", dut.regs[1], dut.z);
        end
        run(4);
        compared++;
        if (dut.pc !== 8'd14) begin
            mismatched++; $display("[TB] FAIL brz_taken_cycle4_pc got %0d want 14", dut.pc);
        end
        run(1);
        compared++;
        if (dut.pc !== 8'd139) begin
            mismatched++; $display("[TB] FAIL brz_taken_pc got %0d want 139", dut.pc);
        end
        run(3);
        compared++;
        if (dut.pc !== 8'd140 || dut.ir !== 8'h00) begin
            mismatched++;
            $display("[TB] FAIL nop139 got pc=%0d ir=%0h want pc=140 ir=00", dut.pc, dut.ir);
        end
    endtask

    task automatic test_write_branch();
        run(5);
        compared++;
        if (dut.Memory.memory[200] !== 8'd40 || dut.pc !== 8'd142) begin
            mismatched++;
            $display("[TB] FAIL wr got mem200=%0d pc=%0d want 40/142",
                     dut.Memory.memory[200], dut.pc);
        end
        run(5);
        compared++;
        if (dut.pc !== 8'd0) begin
            mismatched++; $display("[TB] FAIL br_pc got %0d want 0", dut.pc);
        end
    endtask

    task automatic test_alu_ops();
        @(negedge clk);
        rst = 1'b0;
        #1;
        dut.Memory.memory[0]  = 8'h50; dut.Memory.memory[1] = 8'd128;
        dut.Memory.memory[2]  = 8'h51; dut.Memory.memory[3] = 8'd129;
        dut.Memory.memory[4]  = 8'h14;
        dut.Memory.memory[5]  = 8'h31;
        dut.Memory.memory[6]  = 8'h46;
        dut.Memory.memory[7]  = 8'h2A;
        dut.Memory.memory[8]  = 8'h53; dut.Memory.memory[9] = 8'd131;
        dut.Memory.memory[10] = 8'h1F;
        dut.Memory.memory[11] = 8'h90;
        release_reset();
        run(10);
        run(3);
        compared++;
        if (dut.regs[0] !== 8'd30 || dut.z !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL add got r0=%0d z=%0b want 30/0", dut.regs[0], dut.z);
        end
        run(3);
        compared++;
        if (dut.regs[1] !== 8'd20) begin
            mismatched++; $display("[TB] FAIL and got r1=%0d want 20", dut.regs[1]);
        end
        run(3);
        compared++;
        if (dut.regs[2] !== 8'd235 || dut.z !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL not got r2=%0d z=%0b want 235/0", dut.regs[2], dut.z);
        end
        run(3);
        compared++;
        if (dut.regs[2] !== 8'd0 || dut.z !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL sub_self got r2=%0d z=%0b want 0/1", dut.regs[2], dut.z);
        end
        run(5);
        compared++;
        if (dut.regs[3] !== 8'd40 || dut.z !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL rd_holds_z got r3=%0d z=%0b want 40/1", dut.regs[3], dut.z);
        end
        run(3);
        compared++;
        if (dut.regs[3] !== 8'd80 || dut.z !== 1'b0 || dut.pc !== 8'd11) begin
            mismatched++;
            $display("[TB] FAIL add_self got r3=%0d z=%0b pc=%0d want 80/0/11",
                     dut.regs[3], dut.z, dut.pc);
        end
    endtask

    task automatic test_halt();
        run(3);
        compared++;
        if (dut.pc !== 8'd12) begin
            mismatched++; $display("[TB] FAIL illegal_pc got %0d want 12", dut.pc);
        end
        run(25);
        compared++;
        if (dut.pc !== 8'd12 || dut.ir !== 8'h90 || dut.regs[3] !== 8'd80) begin
            mismatched++;
            $display("[TB] FAIL halt_frozen got pc=%0d ir=%0h r3=%0d want 12/90/80",
                     dut.pc, dut.ir, dut.regs[3]);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        compared++;
        if (dut.pc !== 8'd0 || dut.ir !== 8'h00) begin
            mismatched++;
            $display("[TB] FAIL halt_reset got pc=%0d ir=%0h want 0/00", dut.pc, dut.ir);
        end
        release_reset();
        run(2);
        compared++;
        if (dut.ir !== 8'h50 || dut.pc !== 8'd1) begin
            mismatched++;
            $display("[TB] FAIL restart got ir=%0h pc=%0d want 50/1", dut.ir, dut.pc);
        end
    endtask

    task automatic test_reset_abort();
        @(negedge clk);
        rst = 1'b0;
        #1;
        dut.Memory.memory[0]   = 8'h60;
        dut.Memory.memory[1]   = 8'd210;
        dut.Memory.memory[210] = 8'h55;
        release_reset();
        run(4);
        rst = 1'b0;
        #1;
        compared++;
        if (dut.pc !== 8'd0 || dut.mar !== 8'd0) begin
            mismatched++;
            $display("[TB] FAIL async_reset got pc=%0d mar=%0d want 0/0", dut.pc, dut.mar);
        end
        run(3);
        compared++;
        if (dut.Memory.memory[210] !== 8'h55) begin
            mismatched++;
            $display("[TB] FAIL abort_write got mem210=%0h want 55", dut.Memory.memory[210]);
        end
    endtask

    task automatic test_wrap();
        dut.Memory.memory[0]   = 8'h70;
        dut.Memory.memory[1]   = 8'd2;
        dut.Memory.memory[2]   = 8'd255;
        dut.Memory.memory[255] = 8'h00;
        release_reset();
        run(5);
        compared++;
        if (dut.pc !== 8'd255) begin
            mismatched++; $display("[TB] FAIL wrap_branch_pc got %0d want 255", dut.pc);
        end
        run(3);
        compared++;
        if (dut.pc !== 8'd0 || dut.ir !== 8'h00) begin
            mismatched++;
            $display("[TB] FAIL wrap_pc got pc=%0d ir=%0h want 0/00", dut.pc, dut.ir);
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst        = 1'b0;
        test_reset();
        test_load();
        test_not_taken();
        test_taken();
        test_write_branch();
        test_alu_ops();
        test_halt();
        test_reset_abort();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
